// File: rtl/move_tick_scheduler.sv
// Movement tick divider plus round-robin grant of the shared sprite-movement datapath.
// Optional grant watchdog enabled by defining MOVE_TICK_TIMEOUT_EN.
//   state | meaning
//   IDLE  | no grant; serves the next tick or pending tick
//   GRANT | one requester owns the datapath until done
module move_tick_scheduler #(
  parameter int NREQ = 3,
  parameter int DIV_W = 8,
  parameter logic [DIV_W-1:0] DEF_PERIOD = DIV_W'(4)
`ifdef MOVE_TICK_TIMEOUT_EN
  , parameter int TMO_W = 6
`endif
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic             Sm,
  input  logic             period_ld,
  input  logic [DIV_W-1:0] period_in,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  input  logic             clr_ovr,
  output logic             tick,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             overrun,
  output logic             tmo
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] period_m1;
  logic             wrap;
  logic [0:0]       state;
  logic [LW-1:0]    last;
  logic [LW-1:0]    winner;
  logic [LW-1:0]    idx;
  logic             pending;

  // A zero period behaves as one: wrap on every strobe.
  assign period_m1 = (period == '0) ? '0 : period - 1'b1;
  assign wrap      = Sm && (cnt == period_m1);
  assign busy      = (state == GRANT);

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      cnt    <= '0;
      period <= DEF_PERIOD;
      shadow <= DEF_PERIOD;
      tick   <= 1'b0;
    end else begin
      tick <= wrap;
      if (period_ld) shadow <= period_in;
      if (wrap) begin
        cnt    <= '0;
        period <= shadow;
      end else if (Sm) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Scan farthest-first so the nearest set request after last wins.
  always_comb begin
    winner = last;
    idx    = last;
    for (int i = NREQ; i >= 1; i--) begin
      idx = LW'((int'(last) + i) % NREQ);
      if (req[idx]) winner = idx;
    end
  end

`ifdef MOVE_TICK_TIMEOUT_EN
  logic [TMO_W-1:0] wdog;
  logic [TMO_W-1:0] wdog_nxt;
  logic             wdog_tc;

  assign wdog_nxt = wdog + 1'b1;
  assign wdog_tc  = (wdog_nxt == '1);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      gnt     <= '0;
      last    <= LW'(NREQ - 1);
      pending <= 1'b0;
      overrun <= 1'b0;
`ifdef MOVE_TICK_TIMEOUT_EN
      wdog    <= '0;
      tmo     <= 1'b0;
`endif
    end else begin
      if (clr_ovr) begin
        overrun <= 1'b0;
`ifdef MOVE_TICK_TIMEOUT_EN
        tmo     <= 1'b0;
`endif
      end
      if (state == IDLE) begin
        if (tick || pending) begin
          pending <= 1'b0;
          if (|req) begin
            gnt   <= NREQ'(1) << winner;
            last  <= winner;
            state <= GRANT;
`ifdef MOVE_TICK_TIMEOUT_EN
            wdog  <= '0;
`endif
          end
        end
      end else begin
        // Pending depth is one; a second queued tick is lost.
        if (tick) begin
          if (pending) overrun <= 1'b1;
          else         pending <= 1'b1;
        end
`ifdef MOVE_TICK_TIMEOUT_EN
        wdog <= wdog_nxt;
`endif
        if (done) begin
          gnt   <= '0;
          state <= IDLE;
        end
`ifdef MOVE_TICK_TIMEOUT_EN
        else if (wdog_tc) begin
          gnt   <= '0;
          state <= IDLE;
          tmo   <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_move_tick_scheduler.sv
// Directed bench for move_tick_scheduler: divider, round-robin, discard, overrun, reload, reset.
module tb_move_tick_scheduler;
  logic       CLK = 1'b0;
  logic       Rst = 1'b0;
  logic       Sm = 1'b0;
  logic       period_ld = 1'b0;
  logic [7:0] period_in = 8'd0;
  logic [2:0] req = 3'b000;
  logic       done = 1'b0;
  logic       clr_ovr = 1'b0;
  logic       tick;
  logic [2:0] gnt;
  logic       busy;
  logic       overrun;
  logic       tmo;

  int errors = 0;
  int checks = 0;
  int ntick = 0;
  logic [2:0] rr_exp [4];

  move_tick_scheduler #(
    .NREQ(3), .DIV_W(8), .DEF_PERIOD(8'd4)
`ifdef MOVE_TICK_TIMEOUT_EN
    , .TMO_W(3)
`endif
  ) dut (
    .CLK(CLK), .Rst(Rst), .Sm(Sm), .period_ld(period_ld), .period_in(period_in),
    .req(req), .done(done), .clr_ovr(clr_ovr), .tick(tick), .gnt(gnt),
    .busy(busy), .overrun(overrun), .tmo(tmo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe(input string tag, input logic exp_tick);
    Sm = 1'b1;
    cyc();
    check(tag, 32'(tick), 32'(exp_tick));
    Sm = 1'b0;
    cyc();
  endtask

  task automatic load_period(input logic [7:0] p);
    period_in = p;
    period_ld = 1'b1;
    cyc();
    period_ld = 1'b0;
  endtask

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    #12;
    check("rst_tick", 32'(tick), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_tmo", 32'(tmo), 0);
    check("rst_pending", 32'(dut.pending), 0);
    check("rst_cnt", 32'(dut.cnt), 0);
    check("rst_period", 32'(dut.period), 4);
    cyc();
    Rst = 1'b1;
    cyc();

    // divider: Sm every 3rd cycle, default period 4
    for (int s = 1; s <= 12; s++) begin
      Sm = 1'b1;
      cyc();
      check("div_tick", 32'(tick), 32'(s % 4 == 0));
      if (tick) ntick++;
      Sm = 1'b0;
      cyc();
      check("div_width", 32'(tick), 0);
      cyc();
    end
    check("div_count", 32'(ntick), 3);

    // round-robin with all requesters active
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) strobe("rr_notick", 1'b0);
      Sm = 1'b1;
      cyc();
      check("rr_tick", 32'(tick), 1);
      check("rr_gnt_lag", 32'(gnt), 0);
      Sm = 1'b0;
      cyc();
      check("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
      check("rr_busy", 32'(busy), 1);
      cyc();
      done = 1'b1;
      cyc();
      done = 1'b0;
      check("rr_release", 32'(gnt), 0);
      check("rr_idle", 32'(busy), 0);
    end

    // idle discard
    req = 3'b000;
    for (int s = 0; s < 3; s++) strobe("disc_notick", 1'b0);
    Sm = 1'b1;
    cyc();
    check("disc_tick", 32'(tick), 1);
    Sm = 1'b0;
    cyc();
    check("disc_gnt", 32'(gnt), 0);
    check("disc_pending", 32'(dut.pending), 0);
    check("disc_overrun", 32'(overrun), 0);
    req = 3'b010;
    cyc();
    cyc();
    check("disc_late_req", 32'(gnt), 0);
    for (int s = 0; s < 3; s++) strobe("disc_notick2", 1'b0);
    Sm = 1'b1;
    cyc();
    Sm = 1'b0;
    cyc();
    check("disc_next_gnt", 32'(gnt), 32'b010);
    cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;

    // overrun: shadow=1 takes effect after the current 4-strobe interval
    load_period(8'd1);
    req = 3'b001;
    Sm = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check("ovr_tick", 32'(tick), 1);
    check("ovr_gnt_lag", 32'(gnt), 0);
    cyc();
    check("ovr_gnt", 32'(gnt), 32'b001);
    check("ovr_pend0", 32'(dut.pending), 0);
    cyc();
    check("ovr_pend1", 32'(dut.pending), 1);
    check("ovr_flag0", 32'(overrun), 0);
    Sm = 1'b0;
    cyc();
    check("ovr_flag1", 32'(overrun), 1);
    check("ovr_pend_depth", 32'(dut.pending), 1);
    cyc(); cyc(); cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    check("ovr_gap_gnt", 32'(gnt), 0);
    check("ovr_gap_busy", 32'(busy), 0);
    cyc();
    check("ovr_regnt", 32'(gnt), 32'b001);
    check("ovr_pend_clr", 32'(dut.pending), 0);
    done = 1'b1;
    cyc();
    done = 1'b0;
    check("ovr_sticky", 32'(overrun), 1);
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    check("ovr_clear", 32'(overrun), 0);

    // period reload
    req = 3'b000;
    load_period(8'd4);
    strobe("rl_prime", 1'b1);
    strobe("rl_s1", 1'b0);
    strobe("rl_s2", 1'b0);
    load_period(8'd2);
    strobe("rl_s3", 1'b0);
    strobe("rl_s4", 1'b1);
    strobe("rl_s5", 1'b0);
    strobe("rl_s6", 1'b1);
    strobe("rl_s7", 1'b0);
    strobe("rl_s8", 1'b1);
    load_period(8'd0);
    strobe("rl_s9", 1'b0);
    strobe("rl_s10", 1'b1);
    strobe("rl_zero1", 1'b1);
    strobe("rl_zero2", 1'b1);

    // async reset mid-grant
    req = 3'b001;
    Sm = 1'b1;
    cyc();
    Sm = 1'b0;
    cyc();
    check("rstg_gnt_pre", 32'(gnt), 32'b001);
    check("rstg_busy_pre", 32'(busy), 1);
    #2;
    Rst = 1'b0;
    #1;
    check("rstg_gnt", 32'(gnt), 0);
    check("rstg_busy", 32'(busy), 0);
    check("rstg_pending", 32'(dut.pending), 0);
    cyc();
    Rst = 1'b1;
    cyc();

`ifdef MOVE_TICK_TIMEOUT_EN
    // watchdog: period back to default 4 after reset
    req = 3'b001;
    for (int s = 0; s < 3; s++) strobe("tmo_notick", 1'b0);
    Sm = 1'b1;
    cyc();
    Sm = 1'b0;
    cyc();
    check("tmo_gnt", 32'(gnt), 32'b001);
    for (int c = 0; c < 6; c++) begin
      cyc();
      check("tmo_hold", 32'(gnt), 32'b001);
    end
    cyc();
    check("tmo_drop", 32'(gnt), 0);
    check("tmo_flag", 32'(tmo), 1);
    req = 3'b000;
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    check("tmo_clear", 32'(tmo), 0);
`else
    check("tmo_tied", 32'(tmo), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/move_tick_scheduler.md
Name: move_tick_scheduler

Overview:
- Sequences the shared sprite-movement datapath for Space Invaders.
- Divides the base strobe Sm into a programmable movement tick.
- On each tick, grants the single movement unit to one requester (player, bullet, invader march) in round-robin order. The grant is held until the unit reports done.
- Sits between the Sm strobe source and the position-update datapath; the game logic reloads the period as invaders die, so the march speeds up.

Parameters:
- NREQ, 3, number of requesters (bit 0 = player, 1 = bullet, 2 = invaders).
- DIV_W, 8, width of the tick period register and the strobe counter.
- DEF_PERIOD, 8'd4, period loaded at reset, in Sm strobes per tick.
- TMO_W, 6, width of the grant watchdog counter (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Sm  in  1  base strobe, one CLK wide.
- period_ld  in  1  load period_in into the shadow period register.
- period_in  in  DIV_W  new tick period, in Sm strobes.
- req  in  NREQ  per-requester level request for a movement step.
- done  in  1  shared datapath finished the granted step (one-cycle pulse).
- clr_ovr  in  1  clears the overrun flag.
- tick  out  1  one-cycle pulse at each period boundary.
- gnt  out  NREQ  one-hot grant; all zero when idle.
- busy  out  1  high while in GRANT state.
- overrun  out  1  sticky flag: a tick was lost.
- tmo  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (Rst=0, async) values:
  - cnt=0, period=shadow=DEF_PERIOD, tick=0, gnt=0, busy=0, overrun=0, pending=0, tmo=0.
  - last=NREQ-1, so req[0] has first priority.
- Divider:
  - cnt advances only on Sm.
  - When Sm=1 and cnt==period-1: tick=1 on the next cycle, cnt->0, period<=shadow.
  - A period of 0 is treated as 1, giving a tick on every Sm.
  - period_ld writes shadow only. A new value takes effect at the next wrap; cnt is never truncated.
- Tick latency: one registered cycle after the qualifying Sm.
- FSM states: IDLE, GRANT.
- IDLE: the service condition is (tick | pending).
  - Condition true and req!=0: pick the first set req bit searching from last+1 modulo NREQ. gnt<=one-hot(winner), last<=winner, pending<=0, go to GRANT. gnt rises the cycle after the tick.
  - Condition true and req==0: the tick is discarded and pending<=0.
- GRANT: gnt is held constant, regardless of req changes, until done=1.
  - On done: gnt<=0, go to IDLE. gnt falls the cycle after done.
  - done while in IDLE is ignored.
- Tick while in GRANT (including the done cycle):
  - pending=0: pending<=1.
  - pending=1: overrun<=1; the pending depth stays 1.
- Back-to-back operation: a pending tick is serviced in the first IDLE cycle, so gnt is low for exactly one cycle between grants.
- clr_ovr clears overrun. If it coincides with a new overrun event, the set wins.
- busy equals (state==GRANT).
- Reset mid-grant drops gnt immediately (async) and discards pending.

Optional Feature:
- Macro: MOVE_TICK_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit watchdog clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches all-ones without done: gnt<=0, go to IDLE, tmo<=1 (sticky, cleared by clr_ovr).
  - done in the same cycle as the terminal count takes precedence, and tmo is not set.
- Not defined: no watchdog logic; tmo is driven constant 0, and GRANT waits indefinitely for done.

Test Plan:
- Divider: Rst released, period 4 (default), Sm every 3rd cycle for 12 strobes -> 3 tick pulses, each 1 cycle wide, each one cycle after the 4th, 8th and 12th Sm.
- Round-robin: req=3'b111, done returned 2 cycles after each grant, 4 ticks -> gnt sequence 001, 010, 100, 001.
- Idle discard: req=0 at a tick -> gnt stays 0, pending stays 0, overrun=0. Raising req=3'b010 afterwards gives no grant until the next tick.
- Overrun: period_ld with period_in=1, Sm every cycle, req=3'b001, done withheld 5 cycles -> pending=1 after the first extra tick, overrun=1 after the second. After done: gnt low 1 cycle, then gnt=001 again. clr_ovr -> overrun=0.
- Period reload: period_ld with period_in=2 issued mid-count in period 4 -> the current interval still spans 4 Sm, subsequent intervals span 2. period_in=0 -> a tick on every Sm.
- Reset/timeout: Rst low during GRANT -> gnt=0, busy=0 asynchronously. With MOVE_TICK_TIMEOUT_EN, TMO_W=3, done never asserted -> gnt drops after 7 GRANT cycles and tmo=1.
